// File: rtl/booth_seq_ctrl_if.sv
// Handshake/operand bundle for booth_seq_ctrl.
// The sgn signal exists only when BOOTH_SIGNED_EN is defined.
interface booth_seq_ctrl_if #(
  parameter int N = 4
);
  logic           start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
`ifdef BOOTH_SIGNED_EN
  logic           sgn;
`endif
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*N-1:0] Mul;

  modport master (
    output start, A, B,
`ifdef BOOTH_SIGNED_EN
    output sgn,
`endif
    input  ready, busy, done, Mul
  );

  modport slave (
    input  start, A, B,
`ifdef BOOTH_SIGNED_EN
    input  sgn,
`endif
    output ready, busy, done, Mul
  );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Iterative radix-2 Booth multiplier: one add/sub/shift step per cycle over N+1 cycles.
// Optional feature macro BOOTH_SIGNED_EN adds the sgn input (two's-complement operands).
module booth_seq_ctrl #(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  booth_seq_ctrl_if.slave   bus
);
  localparam int W  = N + 1;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [W:0]     acc;
  logic [W-1:0]   q;
  logic [W-1:0]   m;
  logic           q_m1;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] mul_r;

  logic           a_ext;
  logic           b_ext;
  logic [W:0]     m_sx;
  logic [W:0]     sum;
  logic [W:0]     acc_nx;
  logic [W-1:0]   q_nx;
  logic           qm1_nx;

  // Extension bit applied to the operands at load time.
  always_comb begin
    a_ext = 1'b0;
    b_ext = 1'b0;
`ifdef BOOTH_SIGNED_EN
    a_ext = bus.sgn & bus.A[N-1];
    b_ext = bus.sgn & bus.B[N-1];
`endif
  end

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    m_sx = {m[W-1], m};
    sum  = acc;
    unique case ({q[0], q_m1})
      2'b01:   sum = acc + m_sx;
      2'b10:   sum = acc - m_sx;
      default: sum = acc;
    endcase
    {acc_nx, q_nx, qm1_nx} = {sum[W], sum, q};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: every register, datapath included, is reset so an aborted operation leaves no residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      q     <= '0;
      m     <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
      mul_r <= '0;
    end else begin
      unique case (state)
        CALC: begin
          acc  <= acc_nx;
          q    <= q_nx;
          q_m1 <= qm1_nx;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
            mul_r <= {acc_nx[N-2:0], q_nx};
          end
        end
        default: begin
          // IDLE and DONE behave identically: a start loads, otherwise rest in IDLE.
          if (bus.start) begin
            state <= CALC;
            m     <= {a_ext, bus.A};
            q     <= {b_ext, bus.B};
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= CW'(W);
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.ready = (state != CALC);
  assign bus.busy  = (state == CALC);
  assign bus.done  = (state == DONE);
  assign bus.Mul   = mul_r;
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed self-checking bench for booth_seq_ctrl (N=4); signed vectors run when BOOTH_SIGNED_EN is defined.
module tb_booth_seq_ctrl;
  localparam int N = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  booth_seq_ctrl_if #(.N(N)) bus ();

  booth_seq_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start one operation at a negedge; returns product and the number of cycles
  // after the accepting edge until done is seen (20 means it never came).
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       output logic [2*N-1:0] mul, output int lat);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
`ifdef BOOTH_SIGNED_EN
    bus.sgn   = s;
`endif
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    mul = bus.Mul;
    if (s === 1'bx) lat = 20;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.ready); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
    tests++; if (bus.Mul !== 8'd0) begin fails++; $display("FAIL reset_mul got %h want 00", bus.Mul); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    @(negedge clk);
    bus.A = 4'd15; bus.B = 4'd15; bus.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      tests++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.ready !== 1'b0) begin
        fails++; $display("FAIL basic_busy cycle %0d got busy=%b done=%b ready=%b want 1 0 0", c, bus.busy, bus.done, bus.ready);
      end
    end
    @(negedge clk);
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL basic_done got %b want 1", bus.done); end
    tests++; if (bus.Mul !== 8'd225) begin fails++; $display("FAIL basic_mul got %0d want 225", bus.Mul); end
    tests++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL basic_ready got ready=%b busy=%b want 1 0", bus.ready, bus.busy); end
    @(negedge clk);
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL basic_pulse got done=%b want 0", bus.done); end
    tests++; if (bus.Mul !== 8'd225) begin fails++; $display("FAIL basic_hold got %0d want 225", bus.Mul); end
  endtask

  task automatic test_sweep;
    int gap;
    @(negedge clk);
    bus.A = 4'd0; bus.B = 4'd0; bus.start = 1'b1;
    for (int idx = 0; idx < 256; idx++) begin
      gap = 0;
      @(negedge clk);
      while (bus.done !== 1'b1 && gap < 10) begin
        gap++;
        @(negedge clk);
      end
      tests++;
      if (gap !== 5) begin fails++; $display("FAIL sweep_gap idx %0d got %0d want 5", idx, gap); end
      tests++;
      if (bus.Mul !== 8'((idx / 16) * (idx % 16))) begin
        fails++; $display("FAIL sweep_mul A=%0d B=%0d got %0d want %0d", idx / 16, idx % 16, bus.Mul, (idx / 16) * (idx % 16));
      end
      if (idx == 255) bus.start = 1'b0;
      else begin
        bus.A = 4'((idx + 1) / 16);
        bus.B = 4'((idx + 1) % 16);
      end
    end
    @(negedge clk);
    tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL sweep_end got busy=%b done=%b want 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_signed;
`ifdef BOOTH_SIGNED_EN
    logic [2*N-1:0] mul;
    int lat;
    do_op(4'b1000, 4'b0111, 1'b1, mul, lat);
    tests++; if (mul !== 8'hC8) begin fails++; $display("FAIL signed_m8x7 got %h want c8", mul); end
    do_op(4'b1000, 4'b1000, 1'b1, mul, lat);
    tests++; if (mul !== 8'h40) begin fails++; $display("FAIL signed_m8xm8 got %h want 40", mul); end
    do_op(4'b1111, 4'b0011, 1'b1, mul, lat);
    tests++; if (mul !== 8'hFD) begin fails++; $display("FAIL signed_m1x3 got %h want fd", mul); end
    do_op(4'b1000, 4'b0111, 1'b0, mul, lat);
    tests++; if (mul !== 8'h38) begin fails++; $display("FAIL unsigned_8x7 got %h want 38", mul); end
    tests++; if (lat !== 6) begin fails++; $display("FAIL signed_latency got %0d want 6", lat); end
`endif
  endtask

  task automatic test_ignore_start;
    int extra;
    @(negedge clk);
    bus.A = 4'd3; bus.B = 4'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.A = 4'd7; bus.B = 4'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.A = 4'd0; bus.B = 4'd0;
    repeat (2) @(negedge clk);
    tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL ignore_busy got busy=%b done=%b want 1 0", bus.busy, bus.done); end
    @(negedge clk);
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL ignore_done got %b want 1", bus.done); end
    tests++; if (bus.Mul !== 8'd15) begin fails++; $display("FAIL ignore_mul got %0d want 15", bus.Mul); end
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.ready !== 1'b1) extra++;
    end
    tests++; if (extra !== 0) begin fails++; $display("FAIL ignore_after got %0d bad cycles want 0", extra); end
  endtask

  task automatic test_reset_abort;
    logic [2*N-1:0] mul;
    int lat;
    int seen;
    @(negedge clk);
    bus.A = 4'd9; bus.B = 4'd9; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (bus.busy !== 1'b0 || bus.ready !== 1'b1) begin fails++; $display("FAIL abort_state got busy=%b ready=%b want 0 1", bus.busy, bus.ready); end
    tests++; if (bus.Mul !== 8'd0) begin fails++; $display("FAIL abort_mul got %0d want 0", bus.Mul); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.done === 1'b1) seen++;
      @(negedge clk);
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL abort_done got %0d pulses want 0", seen); end
    do_op(4'd2, 4'd6, 1'b0, mul, lat);
    tests++; if (mul !== 8'd12) begin fails++; $display("FAIL abort_fresh got %0d want 12", mul); end
  endtask

  task automatic test_zero;
    logic [2*N-1:0] mul;
    int lat;
    do_op(4'd0, 4'd15, 1'b0, mul, lat);
    tests++; if (mul !== 8'd0) begin fails++; $display("FAIL zero_a got %0d want 0", mul); end
    tests++; if (lat !== 6) begin fails++; $display("FAIL zero_a_latency got %0d want 6", lat); end
    do_op(4'd15, 4'd0, 1'b0, mul, lat);
    tests++; if (mul !== 8'd0) begin fails++; $display("FAIL zero_b got %0d want 0", mul); end
    tests++; if (lat !== 6) begin fails++; $display("FAIL zero_b_latency got %0d want 6", lat); end
    do_op(4'd11, 4'd13, 1'b0, mul, lat);
    tests++; if (mul !== 8'd143) begin fails++; $display("FAIL mul_11x13 got %0d want 143", mul); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
`ifdef BOOTH_SIGNED_EN
    bus.sgn = 1'b0;
`endif
    test_reset();
    test_basic();
    test_sweep();
    test_signed();
    test_ignore_start();
    test_reset_abort();
    test_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
